// File: rtl/run_len_reporter_pkg.sv
// Shared types and default widths for the run-length reporter slice.
// Holds the FSM state encoding and the default counter widths.
package run_len_reporter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_LEN_W = 8;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/run_len_reporter_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear wins over inc).
// Ports: clk, rst (async, active-low), clr, inc -> q (W bits).
module sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && !(&q)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/run_len_reporter.sv
// Measures runs of z=1 and reports each length on a one-entry
// valid/ready buffer, with saturating totals of reported and dropped
// runs and a sticky overflow flag.
// Ports: clk, rst (async, active-low), clr (sync clear), z,
//   out_valid/out_ready/run_len/run_sat (report buffer),
//   total_runs, drop_cnt, overflow (status).
module run_len_reporter
  import run_len_reporter_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LEN_W-1:0] run_len,
  output logic             run_sat,
  output logic [CNT_W-1:0] total_runs,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             overflow
);

  state_t           state;
  state_t           state_n;
  logic [LEN_W-1:0] len;
  logic             run_end;
  logic             slot;
  logic             load;
  logic             drop;

  assign run_end = (state == RUN) && !z;
  // Buffer can take a report if empty or draining this edge.
  assign slot    = !out_valid || out_ready;
  assign load    = run_end && slot;
  assign drop    = run_end && !slot;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    if (clr) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (z)  state_n = RUN;
        RUN:     if (!z) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Length is zero in IDLE, so the first z=1 counts to 1.
  sat_cnt #(.W(LEN_W)) u_len (
    .clk (clk),
    .rst (rst),
    .clr (clr || run_end),
    .inc (z),
    .q   (len)
  );

  sat_cnt #(.W(CNT_W)) u_total (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (load),
    .q   (total_runs)
  );

  sat_cnt #(.W(CNT_W)) u_drop (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (drop),
    .q   (drop_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      run_len   <= '0;
      run_sat   <= 1'b0;
    end else if (clr) begin
      out_valid <= 1'b0;
      run_len   <= '0;
      run_sat   <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      run_len   <= len;
      run_sat   <= &len;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (clr) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_run_len_reporter.sv
// Self-checking bench for run_len_reporter (LEN_W=4, CNT_W=16).
// Compares every cycle against a run-counting reference model.
module tb_run_len_reporter;

  localparam int LW = 4;
  localparam int CW = 16;
  localparam int LMAX = (1 << LW) - 1;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr = 1'b0;
  logic          z = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [LW-1:0] run_len;
  logic          run_sat;
  logic [CW-1:0] total_runs;
  logic [CW-1:0] drop_cnt;
  logic          overflow;

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  int run_m;
  bit vld_m;
  int len_m;
  bit sat_m;
  int tot_m;
  int drp_m;
  bit ovf_m;

  run_len_reporter #(.LEN_W(LW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .z          (z),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .run_len    (run_len),
    .run_sat    (run_sat),
    .total_runs (total_runs),
    .drop_cnt   (drop_cnt),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [38:0] dut_vec();
    return {out_valid, run_len, run_sat, total_runs, drop_cnt, overflow};
  endfunction

  function automatic logic [38:0] exp_vec();
    logic [LW-1:0] l;
    logic [CW-1:0] t;
    logic [CW-1:0] d;
    l = LW'(len_m);
    t = CW'(tot_m);
    d = CW'(drp_m);
    return {vld_m, l, sat_m, t, d, ovf_m};
  endfunction

  task automatic model_reset();
    run_m = 0;
    vld_m = 0;
    len_m = 0;
    sat_m = 0;
    tot_m = 0;
    drp_m = 0;
    ovf_m = 0;
  endtask

  // A run's reported length is its z=1 count, clipped to LMAX.
  task automatic model_step(input bit zi, input bit ri, input bit ci);
    if (ci) begin
      model_reset();
    end else begin
      if (run_m > 0 && !zi) begin
        if (!vld_m || ri) begin
          vld_m = 1;
          len_m = (run_m > LMAX) ? LMAX : run_m;
          sat_m = (run_m >= LMAX);
          tot_m = (tot_m < CMAX) ? tot_m + 1 : CMAX;
        end else begin
          drp_m = (drp_m < CMAX) ? drp_m + 1 : CMAX;
          ovf_m = 1;
        end
      end else if (vld_m && ri) begin
        vld_m = 0;
      end
      run_m = zi ? run_m + 1 : 0;
    end
  endtask

  task automatic step(input bit zi, input bit ri, input bit ci);
    z = zi;
    out_ready = ri;
    clr = ci;
    model_step(zi, ri, ci);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    rst = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if (dut_vec() !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got %h want 0", dut_vec());
    end
    #2;
    rst = 1'b1;
    step(0, 1, 0);
    n_chk++;
    if (out_valid !== 1'b0 || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_no_report: got %h want %h",
               dut_vec(), exp_vec());
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0);
      n_chk++;
      if (dut_vec() !== exp_vec() || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_run%0d: got %h want %h",
                 i, dut_vec(), exp_vec());
      end
    end
    step(0, 1, 0);
    n_chk++;
    if (out_valid !== 1'b1 || run_len !== 4'd3 || run_sat !== 1'b0 ||
        total_runs !== 16'd1) begin
      n_fail++;
      $display("FAIL basic_report: got v%b l%0d s%b t%0d want v1 l3 s0 t1",
               out_valid, run_len, run_sat, total_runs);
    end
    step(0, 1, 0);
    n_chk++;
    if (out_valid !== 1'b0 || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL basic_drain: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_backpressure();
    step(0, 0, 1);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    n_chk++;
    if (out_valid !== 1'b1 || run_len !== 4'd2) begin
      n_fail++;
      $display("FAIL bp_first: got v%b l%0d want v1 l2",
               out_valid, run_len);
    end
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    step(0, 0, 0);
    n_chk++;
    if (run_len !== 4'd2 || drop_cnt !== 16'd1 || overflow !== 1'b1 ||
        total_runs !== 16'd1 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_drop: got l%0d d%0d o%b t%0d v%b want l2 d1 o1 t1 v1",
               run_len, drop_cnt, overflow, total_runs, out_valid);
    end
    step(0, 1, 0);
    n_chk++;
    if (out_valid !== 1'b0 || overflow !== 1'b1 ||
        dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL bp_drain: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    step(0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    step(0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0);
    step(0, 1, 0);
    n_chk++;
    if (run_len !== 4'd6 || out_valid !== 1'b1 || drop_cnt !== 16'd0 ||
        total_runs !== 16'd2) begin
      n_fail++;
      $display("FAIL accept_report: got l%0d v%b d%0d t%0d want l6 v1 d0 t2",
               run_len, out_valid, drop_cnt, total_runs);
    end
    step(1, 1, 0);
    step(0, 1, 0);
    n_chk++;
    if (run_len !== 4'd1 || out_valid !== 1'b1 || total_runs !== 16'd3) begin
      n_fail++;
      $display("FAIL pulse_len1: got l%0d v%b t%0d want l1 v1 t3",
               run_len, out_valid, total_runs);
    end
  endtask

  task automatic test_saturation();
    step(0, 1, 1);
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 0);
      n_chk++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL sat_no_early: got v%b want v0 at %0d", out_valid, i);
      end
    end
    step(0, 1, 0);
    n_chk++;
    if (run_len !== 4'd15 || run_sat !== 1'b1 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_report: got l%0d s%b v%b want l15 s1 v1",
               run_len, run_sat, out_valid);
    end
    for (int i = 0; i < 15; i++) step(1, 1, 0);
    step(0, 1, 0);
    n_chk++;
    if (run_len !== 4'd15 || run_sat !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_exact: got l%0d s%b want l15 s1", run_len, run_sat);
    end
    for (int i = 0; i < 14; i++) step(1, 1, 0);
    step(0, 1, 0);
    n_chk++;
    if (run_len !== 4'd14 || run_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_below: got l%0d s%b want l14 s0", run_len, run_sat);
    end
  endtask

  task automatic test_clr_priority();
    step(1, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    n_chk++;
    if (overflow !== 1'b1 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_setup: got o%b v%b want o1 v1", overflow, out_valid);
    end
    step(0, 1, 1);
    n_chk++;
    if (out_valid !== 1'b0 || total_runs !== 16'd0 || overflow !== 1'b0 ||
        drop_cnt !== 16'd0 || run_len !== 4'd0) begin
      n_fail++;
      $display("FAIL clr_prio: got v%b t%0d o%b d%0d l%0d want all 0",
               out_valid, total_runs, overflow, drop_cnt, run_len);
    end
    step(0, 1, 0);
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_discard: got v%b want v0", out_valid);
    end
  endtask

  task automatic test_random();
    bit zi;
    bit ri;
    bit ci;
    int longz;
    longz = 0;
    for (int i = 0; i < 3000; i++) begin
      if (longz > 0) begin
        zi = 1;
        longz--;
      end else if ($urandom_range(0, 99) < 3) begin
        zi = 1;
        longz = $urandom_range(10, 25);
      end else begin
        zi = ($urandom_range(0, 99) < 60);
      end
      ri = ($urandom_range(0, 99) < 40);
      ci = ($urandom_range(0, 199) == 0);
      step(zi, ri, ci);
      n_chk++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_cyc%0d: got %h want %h",
                 i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    rst = 1'b0;
    #12;
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_chk++;
    if (dut_vec() !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got %h want 0", dut_vec());
    end
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_clr_priority();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
